// File: rtl/ucsbece154b_fifo_arbiter.sv
// Round-robin arbiter that shares the push port of ucsbece154b_fifo, with locked bursts and owner-ID tagging.
// Optional macro ARB_TIMEOUT_EN releases a lock whose owner has stayed idle for TIMEOUT_CYCLES cycles.
module ucsbece154b_fifo_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NR_REQ         = 2,
  parameter int BURST_MAX      = 4,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NR_REQ-1:0]                     req_valid_i,
  input  logic [NR_REQ-1:0]                     req_last_i,
  input  logic [NR_REQ*DATA_WIDTH-1:0]          req_data_i,
  output logic [NR_REQ-1:0]                     req_ready_o,
  output logic [DATA_WIDTH+$clog2(NR_REQ)-1:0]  fifo_data_o,
  output logic                                  fifo_push_o,
  input  logic                                  fifo_full_i,
  output logic [NR_REQ-1:0]                     grant_o,
  output logic                                  busy_o,
  output logic                                  timeout_o
);

  localparam int IDW = $clog2(NR_REQ);
  localparam int BCW = $clog2(BURST_MAX + 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_MAX);

  if (NR_REQ < 2)         $error("NR_REQ must be >= 2");
  if (BURST_MAX < 1)      $error("BURST_MAX must be >= 1");
  if (TIMEOUT_CYCLES < 1) $error("TIMEOUT_CYCLES must be >= 1");

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [IDW-1:0]   r_owner, w_owner_nxt;
  logic [BCW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [IDW-1:0]   w_g;
  logic             w_has_grant;
  logic             w_xfer;
  logic             w_last;
  logic             w_timeout;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    return (idx == IDW'(NR_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // First valid requester at or after ptr, wrapping modulo NR_REQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [IDW-1:0]    ptr,
                                             input logic [NR_REQ-1:0] valid);
    logic [IDW-1:0] idx;
    logic [IDW-1:0] pick;
    logic           found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NR_REQ; k++) begin
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
    return pick;
  endfunction

  always_comb begin
    w_g         = (r_state == LOCKED) ? r_owner : rr_pick(r_rr_ptr, req_valid_i);
    w_has_grant = !rst_i && ((r_state == LOCKED) || (|req_valid_i));
    w_xfer      = w_has_grant && req_valid_i[w_g] && !fifo_full_i;
    w_last      = req_last_i[w_g];
  end

  assign grant_o     = w_has_grant ? (NR_REQ'(1'b1) << w_g) : '0;
  assign req_ready_o = w_xfer ? (NR_REQ'(1'b1) << w_g) : '0;
  assign fifo_push_o = w_xfer;
  assign fifo_data_o = w_has_grant ? {w_g, req_data_i[w_g*DATA_WIDTH +: DATA_WIDTH]} : '0;
  assign busy_o      = !rst_i && (r_state == LOCKED);
  assign timeout_o   = w_timeout;

  always_comb begin
    // NOTE: every next-state signal is defaulted first so no path through the case can infer a latch.
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (w_last || BURST_MAX == 1) begin
            w_rr_ptr_nxt = next_idx(w_g);
          end else begin
            w_state_nxt    = LOCKED;
            w_owner_nxt    = w_g;
            w_beat_cnt_nxt = BCW'(1);
          end
        end
      end
      LOCKED: begin
        if (w_xfer) begin
          // A burst hitting BURST_MAX is cut here; the owner's leftover beats re-arbitrate.
          if (w_last || (r_beat_cnt + 1'b1 == BURST_LAST)) begin
            w_state_nxt    = IDLE;
            w_rr_ptr_nxt   = next_idx(r_owner);
            w_beat_cnt_nxt = '0;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt    = IDLE;
          w_rr_ptr_nxt   = next_idx(r_owner);
          w_beat_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int ICW = $clog2(TIMEOUT_CYCLES + 1);

  logic [ICW-1:0] r_idle_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive owner-idle cycle; a full FIFO with owner valid resets the count.
  assign w_timeout = !rst_i && (r_state == LOCKED) && !req_valid_i[r_owner] &&
                     (r_idle_cnt == ICW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || (r_state != LOCKED) || req_valid_i[r_owner] || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ucsbece154b_fifo_arbiter.sv
// Self-checking bench for ucsbece154b_fifo_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_ucsbece154b_fifo_arbiter;

  localparam int DW  = 32;
  localparam int NR  = 2;
  localparam int BM  = 4;
  localparam int TO  = 8;
  localparam int IDW = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     valid, last, ready, grant;
  logic [NR*DW-1:0]  data;
  logic [DW+IDW-1:0] fdata;
  logic              push, full, busy, tmo;

  int checks = 0;
  int errors = 0;

  ucsbece154b_fifo_arbiter #(
    .DATA_WIDTH(DW), .NR_REQ(NR), .BURST_MAX(BM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid), .req_last_i(last), .req_data_i(data),
    .req_ready_o(ready), .fifo_data_o(fdata), .fifo_push_o(push),
    .fifo_full_i(full), .grant_o(grant), .busy_o(busy), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  // Reference model: lock flag, owner, beats in current lock, round-robin start, idle run length.
  bit m_locked, n_locked;
  int m_owner, m_beats, m_ptr, m_idle;
  int n_owner, n_beats, n_ptr, n_idle;

  logic [NR-1:0]     e_ready, e_grant;
  logic [DW+IDW-1:0] e_data;
  logic              e_push, e_busy, e_to;
  bit                pend [NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit l, input logic [DW-1:0] d);
    valid[i]        = v;
    last[i]         = l;
    data[i*DW +: DW] = d;
  endtask

  // Lets the combinational path settle, predicts outputs and next model state, compares.
  task automatic settle();
    int g;
    bit xfer;
    #2;
    e_ready = '0; e_grant = '0; e_data = '0; e_push = 1'b0; e_busy = 1'b0; e_to = 1'b0;
    n_locked = m_locked; n_owner = m_owner; n_beats = m_beats; n_ptr = m_ptr; n_idle = m_idle;
    if (rst) begin
      n_locked = 0; n_owner = 0; n_beats = 0; n_ptr = 0; n_idle = 0;
    end else begin
      g = -1;
      if (m_locked) g = m_owner;
      else for (int k = 0; k < NR; k++)
        if (g < 0 && valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      xfer = 1'b0;
      if (g >= 0) begin
        e_grant[g] = 1'b1;
        e_data     = {IDW'(g), data[g*DW +: DW]};
        xfer       = valid[g] && !full;
        e_ready[g] = xfer;
      end
      e_push = xfer;
      e_busy = m_locked;
      if (xfer) begin
        if (!m_locked) begin
          if (last[g] || BM == 1) n_ptr = (g + 1) % NR;
          else begin n_locked = 1; n_owner = g; n_beats = 1; end
        end else if (last[g] || m_beats + 1 == BM) begin
          n_locked = 0; n_ptr = (g + 1) % NR; n_beats = 0;
        end else begin
          n_beats = m_beats + 1;
        end
      end
`ifdef ARB_TIMEOUT_EN
      if (m_locked && !valid[m_owner]) begin
        if (m_idle + 1 == TO) begin
          e_to = 1'b1; n_locked = 0; n_ptr = (m_owner + 1) % NR; n_beats = 0; n_idle = 0;
        end else begin
          n_idle = m_idle + 1;
        end
      end else begin
        n_idle = 0;
      end
`endif
    end
    check("push",    push,  e_push);
    check("data",    fdata, e_data);
    check("ready",   ready, e_ready);
    check("grant",   grant, e_grant);
    check("busy",    busy,  e_busy);
    check("timeout", tmo,   e_to);
    for (int i = 0; i < NR; i++) pend[i] = valid[i] && !e_ready[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_locked = n_locked; m_owner = n_owner; m_beats = n_beats; m_ptr = n_ptr; m_idle = n_idle;
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      settle();
      check("rst_push",  push,  1'b0);
      check("rst_grant", grant, '0);
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    int beat;
    int exp_id [6];
    rst = 1'b1; valid = '0; last = '0; data = '0; full = 1'b0;
    m_locked = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_idle = 0;
    @(posedge clk);
    #1;

    reset_cycles(2);

    // Alternating single-beat grants.
    set_req(0, 1, 1, 32'hA0);
    set_req(1, 1, 1, 32'hB1);
    for (int k = 0; k < 6; k++) begin
      settle();
      check("rr_data", fdata, {IDW'(k % 2), (k % 2 == 1) ? 32'hB1 : 32'hA0});
      check("rr_push", push, 1'b1);
      tick();
    end

    // Three-beat locked burst from req0 while req1 waits.
    for (int k = 0; k < 4; k++) begin
      set_req(0, k < 3, k == 2, 32'h10 + k);
      settle();
      check("lock_id",   fdata[DW +: IDW], (k == 3) ? 1 : 0);
      check("lock_push", push, 1'b1);
      check("lock_busy", busy, (k == 1 || k == 2));
      tick();
    end

    // Endless burst from req0 is cut after BURST_MAX beats.
    exp_id = '{0, 0, 0, 0, 1, 0};
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1, 0, 32'h20 + k);
      settle();
      check("cut_id",   fdata[DW +: IDW], exp_id[k]);
      check("cut_push", push, 1'b1);
      tick();
    end
    reset_cycles(1);

    // Backpressure in the middle of a 4-beat burst.
    set_req(1, 0, 0, '0);
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      full = (c == 2 || c == 3);
      set_req(0, 1, beat == 3, 32'h30 + beat);
      settle();
      check("bp_push",  push, !full);
      check("bp_ready", ready[0], !full);
      check("bp_data",  fdata[DW-1:0], 32'h30 + beat);
      check("bp_busy",  busy, c != 0);
      if (push) beat++;
      tick();
    end
    full = 1'b0;
    set_req(0, 0, 0, '0);

    // Reset pulse after beat 2 of a req1 burst.
    for (int c = 0; c < 4; c++) begin
      rst = (c == 2);
      if (c >= 2) set_req(0, 1, 1, 32'h50);
      set_req(1, 1, 0, 32'h40 + c);
      settle();
      if (c == 2) check("mid_rst_push", push, 1'b0);
      if (c == 3) check("mid_rst_grant", grant, 2'b01);
      tick();
    end
    reset_cycles(1);

    // Owner goes quiet mid-burst.
    set_req(0, 1, 0, 32'h60);
    set_req(1, 1, 1, 32'h61);
    settle();
    tick();
    set_req(0, 0, 0, 32'h60);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= TO; i++) begin
      settle();
      check("to_pulse", tmo, i == TO);
      check("to_grant", grant, 2'b01);
      tick();
    end
    settle();
    check("to_next_grant", grant, 2'b10);
    check("to_next_push",  push, 1'b1);
    tick();
`else
    for (int i = 1; i <= 22; i++) begin
      settle();
      check("hold_grant", grant, 2'b01);
      check("hold_tmo",   tmo, 1'b0);
      tick();
    end
`endif
    reset_cycles(1);

    // Random traffic obeying the requester contract.
    for (int i = 0; i < NR; i++) pend[i] = 0;
    for (int c = 0; c < 800; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      full = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NR; i++)
        if (!pend[i]) set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom);
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_fifo_arbiter.md
Name: ucsbece154b_fifo_arbiter

Overview:
- Round-robin arbiter that shares one request FIFO's push port among NR_REQ requesters.
- Supports multi-beat locked bursts.
- Tags every pushed word with the ID of the requester that produced it, so the consumer can route responses.
- Sits between the requesters and the push side of ucsbece154b_fifo; the FIFO's pop side is untouched.

Parameters:
- DATA_WIDTH, 32: payload width per requester.
- NR_REQ, 2: number of requesters, must be >= 2. ID width IDW = $clog2(NR_REQ).
- BURST_MAX, 4: maximum beats per locked grant, must be >= 1.
- TIMEOUT_CYCLES, 8: idle-owner cycles before forced release. Used only with ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_valid_i  in  NR_REQ  per-requester beat valid
- req_last_i  in  NR_REQ  beat is the last of its burst
- req_data_i  in  NR_REQ*DATA_WIDTH  flat packed payloads; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready_o  out  NR_REQ  beat accepted this cycle
- fifo_data_o  out  DATA_WIDTH+IDW  {owner ID, payload} to the FIFO data_i
- fifo_push_o  out  1  to the FIFO push_i
- fifo_full_i  in  1  from the FIFO full_o
- grant_o  out  NR_REQ  one-hot current owner; 0 when none
- busy_o  out  1  state is LOCKED
- timeout_o  out  1  one-cycle forced-release pulse

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state IDLE, rr_ptr 0, beat_cnt 0, owner 0, idle_cnt 0. All outputs 0 during and after reset.
- Push forcing: fifo_push_o and req_ready_o are forced to 0 in any cycle rst_i=1.
- Transfer rule: a beat transfers when req_valid_i[g] && req_ready_o[g], where g is the granted index.
  - fifo_push_o equals the transfer condition.
  - fifo_data_o = {g, payload_g}.
  - Zero latency: the path is combinational, req to push in the same cycle.
  - req_ready_o[g] = req_valid_i[g] && !fifo_full_i for the granted index only; all other bits are 0.
- Requester contract: valid must not depend on ready. Data and last must be held stable while valid is high and ready is low.
- IDLE state:
  - g = first index with valid set, scanning rr_ptr, rr_ptr+1, ... mod NR_REQ.
  - grant_o shows g combinationally. If no requester is valid, grant_o = 0.
  - If fifo_full_i=1: no transfer, and state, rr_ptr and beat_cnt are unchanged.
  - On a transfer with last=1, or with BURST_MAX=1: stay IDLE, rr_ptr <= (g+1) mod NR_REQ.
  - On a transfer with last=0 and BURST_MAX>1: go to LOCKED, owner <= g, beat_cnt <= 1.
- LOCKED state:
  - g = owner; grant_o = onehot(owner); busy_o=1. All other requesters are blocked.
  - On a transfer, beat_cnt increments.
  - If last=1, or beat_cnt+1 == BURST_MAX: go to IDLE, rr_ptr <= (owner+1) mod NR_REQ, beat_cnt <= 0.
  - A forced termination does not imply last. The owner's remaining beats re-arbitrate as a new request at lowest priority.
  - Owner valid low: bubble (no push), lock held.
  - fifo_full_i=1: no push, beat_cnt held.
- Counters: beat_cnt width $clog2(BURST_MAX+1); it never exceeds BURST_MAX. rr_ptr width IDW and wraps to 0 past NR_REQ-1.
- Reset mid-burst: the burst is abandoned with no push on the reset cycle. The next cycle is IDLE with rr_ptr 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In LOCKED, idle_cnt counts consecutive cycles with req_valid_i[owner]=0, and clears on any owner-valid cycle.
  - When idle_cnt reaches TIMEOUT_CYCLES, the arbiter goes to IDLE, rr_ptr <= (owner+1) mod NR_REQ, beat_cnt <= 0.
  - timeout_o pulses high for exactly that one cycle.
  - A full FIFO with owner valid does not count toward the timeout.
- Undefined: the lock is held indefinitely, idle_cnt is absent, and timeout_o is tied to 0.

Test Plan:
- Reset and round-robin: with rst_i high 2 cycles, all outputs are 0. Then, with req_valid_i=2'b11 held, last=2'b11, data0=0xA0, data1=0xB1, full=0: fifo_data_o sequence is {0,A0},{1,B1},{0,A0},... and fifo_push_o=1 every cycle.
- Locked burst: req0 sends 3 beats (0x10,0x11,0x12, last on the third) while req1 is valid throughout. Pushes are IDs 0,0,0, then ID 1 in cycle 4. busy_o=1 for cycles 1-2 (after beats 1 and 2).
- Forced release: with BURST_MAX=4, req0 streams with last=0 and req1 is valid. Exactly 4 ID-0 pushes occur, then an ID-1 push, then req0 resumes.
- Backpressure: fifo_full_i=1 for 2 cycles after beat 2 of a 4-beat burst gives fifo_push_o=0 and req_ready_o=0 while full, with beat_cnt held at 2. Beats 3-4 follow once full clears, with no reordering.
- Reset mid-burst: rst_i is pulsed after beat 2 of a req1 burst. No push occurs that cycle. The next cycle is IDLE with rr_ptr=0, and req0 (valid) is granted first.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: the req0 owner drops valid mid-burst. timeout_o pulses on the 8th idle cycle, then req1 is granted the next cycle. With the macro undefined, the lock is held for 20+ cycles and timeout_o stays 0.
